// File: rtl/shift_unit_pkg.sv
// shift_unit_pkg: op encodings and FSM state type shared by the shift unit files
package shift_unit_pkg;
  localparam logic [2:0] OP_ZERO = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_LSR  = 3'b010;
  localparam logic [2:0] OP_LSL  = 3'b011;
  localparam logic [2:0] OP_ASR  = 3'b100;
  localparam logic [2:0] OP_INS  = 3'b101;
  localparam logic [2:0] OP_ROR  = 3'b110;
  localparam logic [2:0] OP_ROL  = 3'b111;
  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_e;
endpackage

// File: rtl/shift_unit_step.sv
// shift_step: combinational single-bit step of one shift op; ZERO/LOAD pass x through
module shift_step
  import shift_unit_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [2:0]   op_i,
  input  logic [W-1:0] x_i,
  input  logic         a_i,
  output logic [W-1:0] x_o,
  output logic         b_o
);
  logic left, right, fill;
  assign left  = op_i == OP_LSL || op_i == OP_ROL;
  assign right = op_i == OP_LSR || op_i == OP_ASR || op_i == OP_INS || op_i == OP_ROR;
  assign fill  = op_i == OP_ASR ? x_i[W-1] : op_i == OP_INS ? a_i : op_i == OP_ROR ? x_i[0] : 1'b0;
  assign x_o   = left ? {x_i[W-2:0], op_i == OP_ROL ? x_i[W-1] : 1'b0} :
                 right ? {fill, x_i[W-1:1]} : x_i;
  assign b_o   = left ? x_i[W-1] : x_i[0];
endmodule

// File: rtl/shift_unit.sv
// shift_unit: iterative shifter; define SHIFT_UNIT_BARREL_EN for single-cycle barrel variant
module shift_unit
  import shift_unit_pkg::*;
#(
  parameter  int DATA_LEN = 8,
  localparam int SHAMT_W  = $clog2(DATA_LEN)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                ready,
  input  logic [2:0]          op,
  input  logic [DATA_LEN-1:0] din,
  input  logic [SHAMT_W-1:0]  shamt,
  input  logic                a,
  output logic [DATA_LEN-1:0] dout,
  output logic                done,
  output logic                sout
);
  state_e              state_q, state_d;
  logic [DATA_LEN-1:0] dout_q, dout_d;
  logic                sout_q, sout_d;
  logic                accept;
  assign accept = state_q == ST_IDLE && start;
`ifdef SHIFT_UNIT_BARREL_EN
  logic [DATA_LEN-1:0] bar_x [DATA_LEN];
  logic                bar_b [DATA_LEN];
  assign bar_x[0] = din;
  assign bar_b[0] = 1'b0;
  for (genvar k = 0; k < DATA_LEN - 1; k++) begin : g_bar
    shift_step #(.W(DATA_LEN)) u_step (
      .op_i(op), .x_i(bar_x[k]), .a_i(a), .x_o(bar_x[k+1]), .b_o(bar_b[k+1])
    );
  end
  // whole result is picked from the step chain at accept; LOAD passes through unchanged
  always_comb begin
    state_d = state_q == ST_DONE ? ST_IDLE : state_q;
    dout_d  = dout_q;
    sout_d  = sout_q;
    if (accept) begin
      state_d = ST_DONE;
      dout_d  = op == OP_ZERO ? '0 : bar_x[shamt];
      sout_d  = op == OP_ZERO || op == OP_LOAD || shamt == '0 ? sout_q : bar_b[shamt];
    end
  end
`else
  logic [2:0]          op_q, op_d;
  logic [SHAMT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_LEN-1:0] stp_x;
  logic                stp_b, is_sh;
  assign is_sh = op != OP_ZERO && op != OP_LOAD;
  shift_step #(.W(DATA_LEN)) u_step (
    .op_i(op_q), .x_i(dout_q), .a_i(a), .x_o(stp_x), .b_o(stp_b)
  );
  // accept latches the request, SHIFT applies one step per cycle until cnt runs out
  always_comb begin
    state_d = state_q == ST_DONE ? ST_IDLE : state_q;
    dout_d  = dout_q;
    sout_d  = sout_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    if (accept) begin
      op_d    = op;
      dout_d  = op == OP_ZERO ? '0 : din;
      cnt_d   = is_sh ? shamt : '0;
      state_d = is_sh && shamt != '0 ? ST_SHIFT : ST_DONE;
    end else if (state_q == ST_SHIFT) begin
      dout_d  = stp_x;
      sout_d  = stp_b;
      cnt_d   = cnt_q - 1'b1;
      state_d = cnt_q == SHAMT_W'(1) ? ST_DONE : ST_SHIFT;
    end
  end
`endif
  // state and datapath registers; reset wins over any request in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      dout_q  <= '0;
      sout_q  <= 1'b0;
`ifndef SHIFT_UNIT_BARREL_EN
      op_q    <= OP_ZERO;
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      dout_q  <= dout_d;
      sout_q  <= sout_d;
`ifndef SHIFT_UNIT_BARREL_EN
      op_q    <= op_d;
      cnt_q   <= cnt_d;
`endif
    end
  end
  assign ready = state_q == ST_IDLE;
  assign done  = state_q == ST_DONE;
  assign dout  = dout_q;
  assign sout  = sout_q;
endmodule

// File: tb/tb_shift_unit.sv
// tb_shift_unit: randomized and directed checks of shift_unit against an arithmetic model
module tb_shift_unit;
  import shift_unit_pkg::*;
`ifdef SHIFT_UNIT_BARREL_EN
  localparam bit BARREL = 1'b1;
`else
  localparam bit BARREL = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, a = 1'b0;
  logic [2:0] op = '0, shamt = '0;
  logic [7:0] din = '0, dout;
  logic ready, done, sout;
  int n_chk = 0, n_fail = 0;
  logic m_sout = 1'b0;

  always #5 clk = ~clk;

  shift_unit #(.DATA_LEN(8)) dut (
    .clk(clk), .rst(rst), .start(start), .ready(ready), .op(op), .din(din),
    .shamt(shamt), .a(a), .dout(dout), .done(done), .sout(sout)
  );

  function automatic logic [7:0] ref_dout(logic [2:0] o, logic [7:0] x, int n, logic ai);
    logic [15:0] dd;
    dd = {x, x};
    case (o)
      OP_ZERO: return 8'h00;
      OP_LOAD: return x;
      OP_LSR:  return x >> n;
      OP_LSL:  return x << n;
      OP_ASR:  return 8'($signed(x) >>> n);
      OP_INS:  return (x >> n) | (ai ? ~(8'hFF >> n) : 8'h00);
      OP_ROR:  return 8'(dd >> n);
      default: return 8'((dd << n) >> 8);
    endcase
  endfunction

  function automatic logic ref_sout(logic [2:0] o, logic [7:0] x, int n, logic prev);
    if (o == OP_ZERO || o == OP_LOAD || n == 0) return prev;
    if (o == OP_LSL || o == OP_ROL) return x[8-n];
    return x[n-1];
  endfunction

  task automatic run_op(input logic [2:0] o, input logic [7:0] x, input logic [2:0] n,
                        input logic ai, input bit poke, input int ov, input string nm);
    int lat, exp_lat;
    logic d, gs, exp_s;
    logic [7:0] gd, exp_d;
    exp_d = ov >= 0 ? ov[7:0] : ref_dout(o, x, int'(n), ai);
    exp_s = ref_sout(o, x, int'(n), m_sout);
    exp_lat = (BARREL || o == OP_ZERO || o == OP_LOAD || n == 0) ? 1 : 1 + int'(n);
    @(negedge clk);
    n_chk++;
    if (ready !== 1'b1) begin n_fail++; $display("FAIL %s idle ready: got %b want 1", nm, ready); end
    op = o; din = x; shamt = n; a = ai; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; op = 3'($urandom); din = 8'($urandom); shamt = 3'($urandom);
    lat = 0; d = 1'b0; gd = '0; gs = 1'b0;
    while (!d && lat < 40) begin
      @(negedge clk);
      d = done; gd = dout; gs = sout;
      if (!d) begin
        n_chk++;
        if (ready !== 1'b0) begin n_fail++; $display("FAIL %s busy ready: got %b want 0", nm, ready); end
      end
      if (poke && lat == 0) begin start = 1'b1; op = 3'($urandom); din = ~x; shamt = 3'($urandom); end
      @(posedge clk);
      lat++;
      #1 start = 1'b0;
    end
    n_chk++;
    if (lat != exp_lat) begin n_fail++; $display("FAIL %s latency: got %0d want %0d", nm, lat, exp_lat); end
    n_chk++;
    if (gd !== exp_d) begin n_fail++; $display("FAIL %s dout: got %h want %h", nm, gd, exp_d); end
    n_chk++;
    if (gs !== exp_s) begin n_fail++; $display("FAIL %s sout: got %b want %b", nm, gs, exp_s); end
    n_chk++;
    if (done !== 1'b0 || ready !== 1'b1) begin
      n_fail++; $display("FAIL %s after done: done=%b ready=%b want 0/1", nm, done, ready);
    end
    n_chk++;
    if (dout !== exp_d) begin n_fail++; $display("FAIL %s dout hold: got %h want %h", nm, dout, exp_d); end
    m_sout = exp_s;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if (dout !== 8'h00 || sout !== 1'b0 || ready !== 1'b1 || done !== 1'b0) begin
      n_fail++; $display("FAIL reset: dout=%h sout=%b ready=%b done=%b want 00/0/1/0", dout, sout, ready, done);
    end
    rst = 1'b0;
    m_sout = 1'b0;
  endtask

  task automatic test_directed();
    run_op(OP_LSR, 8'h96, 3'd3, 1'b0, 1'b0, 8'h12, "lsr3");
    n_chk++;
    if (m_sout !== 1'b1 || sout !== 1'b1) begin n_fail++; $display("FAIL lsr3 sout: got %b want 1", sout); end
    run_op(OP_ASR, 8'h96, 3'd2, 1'b0, 1'b0, 8'hE5, "asr2");
    run_op(OP_LSL, 8'h96, 3'd3, 1'b0, 1'b0, 8'hB0, "lsl3");
    run_op(OP_ROL, 8'h96, 3'd1, 1'b0, 1'b0, 8'h2D, "rol1");
    run_op(OP_ROR, 8'h96, 3'd4, 1'b0, 1'b0, 8'h69, "ror4");
    run_op(OP_INS, 8'h00, 3'd3, 1'b1, 1'b0, 8'hE0, "ins3");
    run_op(OP_LSR, 8'h5A, 3'd0, 1'b0, 1'b0, 8'h5A, "lsr0");
    run_op(OP_ROL, 8'h81, 3'd7, 1'b0, 1'b0, 8'hC0, "rol7");
    run_op(OP_ZERO, 8'hA5, 3'd5, 1'b1, 1'b0, 8'h00, "zero");
    run_op(OP_LOAD, 8'h3C, 3'd6, 1'b0, 1'b0, 8'h3C, "load");
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++)
      run_op(3'($urandom), 8'($urandom), 3'($urandom), 1'($urandom), 1'b0, -1, "rand");
  endtask

  task automatic test_start_ignored();
    run_op(OP_LSR, 8'h96, 3'd5, 1'b0, 1'b1, -1, "poke_lsr5");
    run_op(OP_ROR, 8'hC3, 3'd6, 1'b0, 1'b1, -1, "poke_ror6");
  endtask

  task automatic test_reset_mid();
    bit seen;
    @(negedge clk);
    op = OP_LSR; din = 8'hF7; shamt = 3'd5; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    n_chk++;
    if (dout !== 8'h00 || ready !== 1'b1 || done !== 1'b0 || sout !== 1'b0) begin
      n_fail++; $display("FAIL mid reset: dout=%h ready=%b done=%b sout=%b want 00/1/0/0", dout, ready, done, sout);
    end
    rst = 1'b0;
    m_sout = 1'b0;
    seen = 1'b0;
    repeat (8) @(negedge clk) if (done !== 1'b0) seen = 1'b1;
    n_chk++;
    if (seen) begin n_fail++; $display("FAIL mid reset done: got pulse want none"); end
    run_op(OP_LSL, 8'h0F, 3'd2, 1'b0, 1'b0, -1, "after_reset");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_start_ignored();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
